// File: rtl/mips_pkg.sv
// Shared types and constants for the sequential MIPS multiply/divide unit.
package mips_pkg;

  localparam int unsigned MULDIV_DATA_WIDTH = 32;
  localparam int unsigned MULDIV_CNT_WIDTH  = $clog2(MULDIV_DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    OpMult  = 2'd0,
    OpMultu = 2'd1,
    OpDiv   = 2'd2,
    OpDivu  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
module mips_muldiv_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  is_div_i,
  input  logic [DATA_WIDTH-1:0] acc_hi_i,
  input  logic [DATA_WIDTH-1:0] acc_lo_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  output logic [DATA_WIDTH-1:0] acc_hi_o,
  output logic [DATA_WIDTH-1:0] acc_lo_o
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH+1:0] diff;

  always_comb begin
    sum    = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : '0);
    rem_sh = {acc_hi_i, acc_lo_i[DATA_WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, operand_i};
    if (is_div_i) begin
      // Borrow out means the divisor did not fit: keep the shifted remainder.
      if (diff[DATA_WIDTH+1]) begin
        acc_hi_o = rem_sh[DATA_WIDTH-1:0];
        acc_lo_o = {acc_lo_i[DATA_WIDTH-2:0], 1'b0};
      end else begin
        acc_hi_o = diff[DATA_WIDTH-1:0];
        acc_lo_o = {acc_lo_i[DATA_WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_hi_o = sum[DATA_WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mips_muldiv_seq
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  muldiv_op_t            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  hilo_rd,
  input  logic                  abort,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q;
  logic [MULDIV_CNT_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] acc_hi_q, acc_lo_q, divisor_q;
  logic [DATA_WIDTH-1:0] step_hi, step_lo;
  logic [DATA_WIDTH-1:0] hi_q, lo_q;
  logic neg_q, rem_neg_q, zero_q, done_q, div_zero_q;
  logic launch, fix_wr;

  logic signed_op, is_div, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;
  logic [DATA_WIDTH-1:0] res_hi, res_lo;

  // Operand magnitudes are taken at issue so the iterative core is sign-agnostic.
  always_comb begin
    signed_op = (op == OpMult) || (op == OpDiv);
    a_neg     = signed_op & src_a[DATA_WIDTH-1];
    b_neg     = signed_op & src_b[DATA_WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    is_div    = (op_q == OpDiv) || (op_q == OpDivu);
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    fix_wr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRun;
          launch  = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == MULDIV_CNT_WIDTH'(DATA_WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        fix_wr  = !abort;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  mips_muldiv_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .is_div_i (is_div),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .operand_i(divisor_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OpMult;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
    end else if (launch) begin
      op_q      <= op;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= a_mag;
      divisor_q <= b_mag;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      zero_q    <= (src_b == '0);
    end else if (state_q == StRun) begin
      cnt_q    <= cnt_q + 1'b1;
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient regardless of sign.
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
    if (is_div) begin
      res_hi = rem_neg_q ? -acc_hi_q : acc_hi_q;
      res_lo = zero_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    end else begin
      res_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      res_lo = prod_fix[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= fix_wr;
      div_zero_q <= fix_wr & is_div & zero_q;
      if (fix_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == StIdle && !start) begin
        if (mthi) hi_q <= wr_data;
        if (mtlo) lo_q <= wr_data;
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign stall    = busy & (start | hilo_rd | mthi | mtlo);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Scoreboard bench for mips_muldiv_seq: random ops against an arithmetic reference model.
module tb_mips_muldiv_seq;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  muldiv_op_t  op = OpMult;
  logic [31:0] src_a = '0, src_b = '0, wr_data = '0;
  logic        mthi = 1'b0, mtlo = 1'b0, hilo_rd = 1'b0, abort = 1'b0;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_muldiv_seq #(
    .DATA_WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wr_data (wr_data),
    .hilo_rd (hilo_rd),
    .abort   (abort),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics from plain integer arithmetic.
  function automatic exp_t model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    longint      sp;
    logic [63:0] up;
    int          sa, sb_v;
    r.dz = 1'b0;
    case (o)
      OpMult: begin
        sp   = longint'($signed(a)) * longint'($signed(b));
        r.hi = sp[63:32];
        r.lo = sp[31:0];
      end
      OpMultu: begin
        up   = {32'h0, a} * {32'h0, b};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      OpDiv: begin
        sa   = a;
        sb_v = b;
        if (b == 32'h0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = a;
          r.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000;
          r.hi = 32'h0;
        end else begin
          r.lo = sa / sb_v;
          r.hi = sa % sb_v;
        end
      end
      default: begin
        if (b == 32'h0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = a;
          r.dz = 1'b1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_hi", {32'h0, hi}, {32'h0, e.hi});
        chk("res_lo", {32'h0, lo}, {32'h0, e.lo});
        chk("res_div_zero", {63'h0, div_zero}, {63'h0, e.dz});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int pc;
    int kd;
    pc = poke ? int'($urandom_range(3, 25)) : -1;
    kd = 0;
    op = o; src_a = a; src_b = b; start = 1'b1;
    sb.push_back(model(o, a, b));
    for (int k = 1; k <= 60 && kd == 0; k++) begin
      tick();
      start = 1'b0;
      mtlo  = 1'b0;
      if (k == pc) begin
        start   = 1'b1;
        op      = muldiv_op_t'($urandom_range(0, 3));
        src_a   = $urandom;
        src_b   = $urandom;
        mtlo    = 1'b1;
        wr_data = $urandom;
      end
      if (done) kd = k;
    end
    if (kd == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got no done expected done within 60 cycles");
      sb.delete();
    end else begin
      chk("latency", 64'(kd), 64'd34);
    end
    tick();
  endtask

  task automatic move(input bit to_hi, input logic [31:0] d);
    wr_data = d;
    mthi = to_hi;
    mtlo = !to_hi;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    chk(to_hi ? "mthi" : "mtlo", {32'h0, to_hi ? hi : lo}, {32'h0, d});
  endtask

  initial begin
    logic [31:0] hs, ls;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {busy, stall, done, div_zero, hi, lo}, '0);
    rst_n = 1'b1;
    tick();

    // MULT -2 * 3 with cycle-accurate busy/done checks.
    op = OpMult; src_a = 32'hFFFF_FFFE; src_b = 32'd3; start = 1'b1;
    sb.push_back(model(OpMult, 32'hFFFF_FFFE, 32'd3));
    for (int k = 1; k <= 35; k++) begin
      tick();
      start = 1'b0;
      chk("busy_cyc", {63'h0, busy}, {63'h0, (k <= 33)});
      chk("done_cyc", {63'h0, done}, {63'h0, (k == 34)});
    end
    chk("mult_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'h0, lo}, 64'hFFFF_FFFA);

    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi", {32'h0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'h0, lo}, 64'h0000_0001);
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", {32'h0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_lo", {32'h0, lo}, 64'h8000_0000);
    chk("divovf_hi", {32'h0, hi}, 64'h0);
    run_op(OpDivu, 32'd10, 32'd0, 1'b0);
    chk("divz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
    chk("divz_hi", {32'h0, hi}, 64'h0000_000A);

    // Abort mid-flight: stall, ignored mthi, hi/lo untouched, no done.
    move(1'b1, 32'hAAAA_5555);
    move(1'b0, 32'h1111_EEEE);
    hs = hi; ls = lo;
    op = OpMultu; src_a = $urandom; src_b = $urandom; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      start = 1'b0; hilo_rd = 1'b0; mthi = 1'b0; abort = 1'b0;
      if (k == 5) begin
        hilo_rd = 1'b1; mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
        #1;
        chk("stall", {63'h0, stall}, 64'h1);
      end
      if (k == 10) abort = 1'b1;
    end
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_hi", {32'h0, hi}, {32'h0, hs});
    chk("abort_lo", {32'h0, lo}, {32'h0, ls});
    repeat (40) tick();

    // abort and start together in idle: nothing may start.
    op = OpMult; src_a = 32'd5; src_b = 32'd5; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_wins", {63'h0, busy}, 64'h0);

    // Asynchronous reset in cycle 20 of a DIV.
    op = OpDiv; src_a = 32'h0001_2345; src_b = 32'd7; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, stall, done, div_zero, hi, lo}, '0);
    tick();
    rst_n = 1'b1;
    move(1'b0, 32'h0000_1234);
    chk("postrst_hi", {32'h0, hi}, 64'h0);

    for (int i = 0; i < 40; i++) begin
      run_op(muldiv_op_t'($urandom_range(0, 3)), rnd_val(), rnd_val(), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) move($urandom_range(0, 1) == 1, $urandom);
    end

    repeat (3) tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
